// File: rtl/fp32_align_stage.sv
// FP32 operand alignment front-end: magnitude ordering, exponent-difference shift,
// sticky tracking and a credit-controlled output FIFO that absorbs downstream stalls.

module barrel_shifter #(
  parameter int SIZE       = 27,
  parameter int SHIFT_SIZE = 8,
  parameter int SHIFT_LEFT = 0
) (
  input  logic                  clk,
  input  logic [SIZE-1:0]       i_data,
  input  logic [SHIFT_SIZE-1:0] i_shift,
  output logic [SIZE-1:0]       o_data
);
  localparam int LV = $clog2(SIZE);
  localparam int SL = (LV >= 3) ? (LV + 1) / 2 : 1;

  logic [SIZE-1:0]       r_data  [SL];
  logic [SHIFT_SIZE-1:0] r_shift [SL];

  // Levels lo..hi-1 of the log shifter; the last stage also clears on oversized shifts.
  function automatic logic [SIZE-1:0] shift_levels(input logic [SIZE-1:0] d,
                                                   input logic [SHIFT_SIZE-1:0] amt,
                                                   input int lo, input int hi);
    logic [SIZE-1:0] v;
    v = d;
    for (int k = 0; k < LV; k++) begin
      if (k >= lo && k < hi && amt[k]) begin
        v = (SHIFT_LEFT != 0) ? (v << (1 << k)) : (v >> (1 << k));
      end
    end
    if (hi >= LV && (amt >> LV) != '0) begin
      v = '0;
    end
    return v;
  endfunction

  // Two shift levels per register stage.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SL; s++) begin
      if (s == 0) begin
        r_data[0]  <= shift_levels(i_data, i_shift, 0, (SL == 1) ? LV : 2);
        r_shift[0] <= i_shift;
      end else begin
        r_data[s]  <= shift_levels(r_data[s-1], r_shift[s-1], 2 * s,
                                   (s == SL - 1) ? LV : 2 * s + 2);
        r_shift[s] <= r_shift[s-1];
      end
    end
  end

  assign o_data = r_data[SL-1];
endmodule

module fp32_align_stage_chk #(
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          pop,
  input logic          accept,
  input logic [CW-1:0] count,
  input logic [CW-1:0] inflight
);
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CW'(FIFO_DEPTH))));
  a_inflight_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !accept && (inflight == '0)));
endmodule

module fp32_align_stage #(
  parameter int FIFO_DEPTH = 8,
  parameter int GUARD_BITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_exp,
  output logic                     out_sign_big,
  output logic                     out_sign_small,
  output logic [24+GUARD_BITS-1:0] out_mant_big,
  output logic [24+GUARD_BITS-1:0] out_mant_small,
  output logic                     out_sticky,
  output logic                     out_swapped,
  output logic                     out_special
);
  localparam int MW  = 24 + GUARD_BITS;
  localparam int LV  = $clog2(MW);
  localparam int SL  = (LV >= 3) ? (LV + 1) / 2 : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SBW = MW + 13;
  localparam int FW  = SBW + MW;

  logic          w_b_big, w_sticky, w_special, w_accept, w_push, w_pop;
  logic [31:0]   w_big, w_small;
  logic [MW-1:0] w_mant_big, w_mant_small, w_shift_out;
  logic [7:0]    w_diff;
  logic [CW:0]   w_credit;
  logic [SBW-1:0] w_s0_side;
  logic [FW-1:0]  w_wdata, w_head;

  logic          r_s0_valid, r_s0_sign_big, r_s0_sign_small, r_s0_sticky;
  logic          r_s0_swapped, r_s0_special;
  logic [7:0]    r_s0_exp, r_s0_diff;
  logic [MW-1:0] r_s0_mant_big, r_s0_mant_small;

  logic           r_vld  [SL];
  logic [SBW-1:0] r_side [SL];
  logic [FW-1:0]  r_mem  [FIFO_DEPTH];
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count, r_inflight;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Order operands by {exp, frac}; ties keep A as the big operand.
  always_comb begin
    w_b_big = in_b[30:0] > in_a[30:0];
    if (w_b_big) begin
      w_big   = in_b;
      w_small = in_a;
    end else begin
      w_big   = in_a;
      w_small = in_b;
    end
    if (w_big[30:23] == 8'd0) begin
      w_mant_big = '0;
    end else begin
      w_mant_big = {1'b1, w_big[22:0], {GUARD_BITS{1'b0}}};
    end
    if (w_small[30:23] == 8'd0) begin
      w_mant_small = '0;
    end else begin
      w_mant_small = {1'b1, w_small[22:0], {GUARD_BITS{1'b0}}};
    end
    w_diff    = w_big[30:23] - w_small[30:23];
    w_special = (in_a[30:23] == 8'hFF) || (in_b[30:23] == 8'hFF);
  end

  // Sticky: every bit the shifter will drop, i.e. positions below diff.
  always_comb begin
    w_sticky = 1'b0;
    for (int i = 0; i < MW; i++) begin
      if (i < int'(w_diff)) begin
        w_sticky = w_sticky | w_mant_small[i];
      end else begin
        w_sticky = w_sticky;
      end
    end
  end

  assign w_credit = (CW+1)'(r_count) + (CW+1)'(r_inflight);
  assign in_ready = !rst && (w_credit < (CW+1)'(FIFO_DEPTH));
  assign w_accept = in_valid && in_ready;

  // S0 valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
    end else begin
      r_s0_valid <= w_accept;
    end
  end

  // S0 data capture on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s0_exp        <= w_big[30:23];
      r_s0_sign_big   <= w_big[31];
      r_s0_sign_small <= w_small[31];
      r_s0_mant_big   <= w_mant_big;
      r_s0_mant_small <= w_mant_small;
      r_s0_diff       <= w_diff;
      r_s0_sticky     <= w_sticky;
      r_s0_swapped    <= w_b_big;
      r_s0_special    <= w_special;
    end
  end

  barrel_shifter #(.SIZE(MW), .SHIFT_SIZE(8), .SHIFT_LEFT(0)) u_shifter (
    .clk     (clk),
    .i_data  (r_s0_mant_small),
    .i_shift (r_s0_diff),
    .o_data  (w_shift_out)
  );

  assign w_s0_side = {r_s0_exp, r_s0_sign_big, r_s0_sign_small, r_s0_mant_big,
                      r_s0_sticky, r_s0_swapped, r_s0_special};

  // Valid pipeline matching shifter latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SL; s++) begin
        r_vld[s] <= 1'b0;
      end
    end else begin
      r_vld[0] <= r_s0_valid;
      for (int s = 1; s < SL; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
    end
  end

  // Sideband pipeline matching shifter latency.
  always_ff @(posedge clk) begin
    r_side[0] <= w_s0_side;
    for (int s = 1; s < SL; s++) begin
      r_side[s] <= r_side[s-1];
    end
  end

  assign w_push  = r_vld[SL-1];
  assign w_wdata = {r_side[SL-1], w_shift_out};
  assign out_valid = !rst && (r_count != '0);
  assign w_pop   = out_valid && out_ready;

  // In-flight credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // FIFO occupancy and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        r_wptr <= next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
    end
  end

  // FIFO storage; write on pipeline exit is unconditional.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wdata;
    end
  end

  assign w_head         = r_mem[r_rptr];
  assign out_mant_small = w_head[MW-1:0];
  assign out_special    = w_head[MW];
  assign out_swapped    = w_head[MW+1];
  assign out_sticky     = w_head[MW+2];
  assign out_mant_big   = w_head[2*MW+2:MW+3];
  assign out_sign_small = w_head[2*MW+3];
  assign out_sign_big   = w_head[2*MW+4];
  assign out_exp        = w_head[2*MW+12:2*MW+5];

  fp32_align_stage_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .pop      (w_pop),
    .accept   (w_accept),
    .count    (r_count),
    .inflight (r_inflight)
  );
endmodule

// File: tb/tb_fp32_align_stage.sv
// Randomized and directed bench for fp32_align_stage against an arithmetic reference model.

module tb_fp32_align_stage;
  typedef struct packed {
    logic [7:0]  exp;
    logic        sb;
    logic        ss;
    logic [26:0] mb;
    logic [26:0] ms;
    logic        st;
    logic        sw;
    logic        sp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_exp;
  logic        out_sign_big, out_sign_small, out_sticky, out_swapped, out_special;
  logic [26:0] out_mant_big, out_mant_small;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  res_t exp_q[$];
  int   due_q[$];

  fp32_align_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_sign_big(out_sign_big), .out_sign_small(out_sign_small),
    .out_mant_big(out_mant_big), .out_mant_small(out_mant_small),
    .out_sticky(out_sticky), .out_swapped(out_swapped), .out_special(out_special)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [31:0] big, sml;
    longint mb, ms;
    int d;
    r.sw  = (b[30:0] > a[30:0]);
    big   = r.sw ? b : a;
    sml   = r.sw ? a : b;
    r.exp = big[30:23];
    r.sb  = big[31];
    r.ss  = sml[31];
    mb = (big[30:23] == 8'd0) ? 64'd0 : (longint'(big[22:0]) + 64'd8388608) * 64'd8;
    ms = (sml[30:23] == 8'd0) ? 64'd0 : (longint'(sml[22:0]) + 64'd8388608) * 64'd8;
    d  = int'(big[30:23]) - int'(sml[30:23]);
    r.mb = 27'(mb);
    if (d >= 27) begin
      r.ms = 27'd0;
      r.st = (ms != 64'd0);
    end else begin
      r.ms = 27'(ms >> d);
      r.st = ((ms % (64'd1 << d)) != 64'd0);
    end
    r.sp = (a[30:23] == 8'd255) || (b[30:23] == 8'd255);
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int m;
    m = int'($urandom_range(0, 15));
    if (m == 0)      e = 8'd0;
    else if (m == 1) e = 8'd255;
    else             e = 8'(100 + $urandom_range(0, 40));
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Scoreboard: check handshakes, flow control and head contents every cycle.
  always @(negedge clk) begin
    res_t h, e;
    bit exp_ov, ok;
    if (rst) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
      end
      exp_q.delete();
      due_q.delete();
    end else begin
      checks++;
      if (in_ready !== (exp_q.size() < 8)) begin
        errors++;
        $display("FAIL in_ready cyc=%0d got=%b required=%b", cyc, in_ready, exp_q.size() < 8);
      end
      exp_ov = (exp_q.size() > 0) && (due_q[0] <= cyc);
      checks++;
      if (out_valid !== exp_ov) begin
        errors++;
        $display("FAIL out_valid cyc=%0d got=%b required=%b", cyc, out_valid, exp_ov);
      end
      if (exp_ov && out_valid === 1'b1) begin
        h = {out_exp, out_sign_big, out_sign_small, out_mant_big, out_mant_small,
             out_sticky, out_swapped, out_special};
        e = exp_q[0];
        if (e.sp) ok = ({h.exp, h.sb, h.ss, h.sw, h.sp} === {e.exp, e.sb, e.ss, e.sw, e.sp});
        else      ok = (h === e);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL head cyc=%0d got exp=%h sb=%b ss=%b mb=%h ms=%h st=%b sw=%b sp=%b required exp=%h sb=%b ss=%b mb=%h ms=%h st=%b sw=%b sp=%b",
                   cyc, h.exp, h.sb, h.ss, h.mb, h.ms, h.st, h.sw, h.sp,
                   e.exp, e.sb, e.ss, e.mb, e.ms, e.st, e.sw, e.sp);
        end
      end
      if (exp_ov && out_ready) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b));
        due_q.push_back(cyc + 5);
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic pin(input string name, input res_t got, input res_t req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pa [12];
    logic [31:0] pb [12];
    int idx, acc0, n;

    // Hand-computed expectations pinning the model.
    pin("model_basic", model(32'h3F800000, 32'h3F000000),
        {8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b0});
    pin("model_swap", model(32'h3F000000, 32'h40000000),
        {8'h80, 1'b0, 1'b0, 27'h4000000, 27'h1000000, 1'b0, 1'b1, 1'b0});
    pin("model_tie", model(32'h3F800000, 32'h3F800000),
        {8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0});
    pin("model_diff24", model(32'h3F800000, 32'h33800001),
        {8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h0000004, 1'b1, 1'b0, 1'b0});
    pin("model_diff37", model(32'h3F800000, 32'h2D000000),
        {8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h0000000, 1'b1, 1'b0, 1'b0});
    pin("model_zero", model(32'h3F800000, 32'h00000000),
        {8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h0000000, 1'b0, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Directed vectors, first one alone to observe empty-FIFO latency.
    send(32'h3F800000, 32'h3F000000);
    drain();
    send(32'h3F000000, 32'h40000000);
    send(32'h3F800000, 32'h3F800000);
    send(32'h3F800000, 32'h33800001);
    send(32'h3F800000, 32'h2D000000);
    send(32'h3F800000, 32'h00000000);
    send(32'h7F800000, 32'h3F800000);
    send(32'h3F800000, 32'h7FC00000);
    send(32'hBF800000, 32'h40400000);
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = rand_fp();
      in_b = ($urandom_range(0, 7) == 0) ? in_a : rand_fp();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: 12 offered, 8 credits.
    for (int i = 0; i < 12; i++) begin
      pa[i] = rand_fp();
      pb[i] = rand_fp();
    end
    out_ready = 1'b0;
    acc0 = acc_cnt;
    idx = 0;
    in_valid = 1'b1;
    in_a = pa[0];
    in_b = pb[0];
    repeat (20) begin
      @(negedge clk);
      if (in_ready && idx < 12) idx++;
      @(posedge clk); #1;
      if (idx < 12) begin in_a = pa[idx]; in_b = pb[idx]; end
      else in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (acc_cnt - acc0 != 8 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_credits accepted=%0d in_ready=%b required 8/0", acc_cnt - acc0, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while (idx < 12 && n < 100) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 12) begin in_a = pa[idx]; in_b = pb[idx]; end
      else in_valid = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cnt - acc0 != 12) begin
      errors++;
      $display("FAIL backpressure_resume accepted=%0d required 12", acc_cnt - acc0);
    end
    drain();

    // Reset with 2 buffered and 3 in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(rand_fp(), rand_fp());
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) send(rand_fp(), rand_fp());
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp32_align_stage.md
Name: fp32_align_stage

Overview:
- Front-end of the FP32 add/accumulate path in the NIC reduction engine.
- Accepts operand pairs and orders them by magnitude. Computes the exponent difference and drives it as the shift amount into an internal right-shifting barrel_shifter (SHIFT_LEFT=0).
- Tracks sticky bits, matches the shifter's fixed latency with a valid/sideband pipeline, and buffers results in an output FIFO. The FIFO lets the downstream adder/normalizer apply backpressure even though the shifter cannot stall.

Parameters:
- FIFO_DEPTH, 8: output FIFO entries; must be >= total latency + 1.
- GUARD_BITS, 3: guard bits appended below the 24-bit significand. Aligned mantissa width MW = 24 + GUARD_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  pair accepted when in_valid && in_ready
- in_a  in  32  IEEE-754 FP32 operand A
- in_b  in  32  IEEE-754 FP32 operand B
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream pops when out_valid && out_ready
- out_exp  out  8  exponent of larger operand
- out_sign_big  out  1  sign of larger operand
- out_sign_small  out  1  sign of smaller operand
- out_mant_big  out  MW  larger significand, hidden bit included, << GUARD_BITS
- out_mant_small  out  MW  smaller significand, same format, right-shifted by the exponent difference
- out_sticky  out  1  OR of all bits shifted out of out_mant_small
- out_swapped  out  1  1 if B was the larger operand
- out_special  out  1  either operand has exponent 255 (Inf/NaN); mantissa fields unspecified

Behaviour:
- Reset:
  - Clears FIFO pointers/count, the in-flight valid pipeline and the in-flight counter.
  - out_valid=0 and in_ready=0 while rst=1. in_ready may rise the first cycle after rst deasserts.
  - Reset mid-operation discards all in-flight and buffered entries. Shifter data registers need no reset.
- Decode (stage S0, registered on accept):
  - Exponent 0 is flushed to zero: significand 0, hidden bit 0. Otherwise hidden bit = 1.
  - Each significand is extended to MW bits: {hidden, frac, GUARD_BITS zeros}.
- Magnitude compare on {exp, frac}: B is big iff B > A strictly. Ties choose A (out_swapped=0).
- Shift amount: diff = exp_big - exp_small, 8 bits unsigned, sent to the barrel_shifter shift input (SHIFT_SIZE=8, SIZE=MW).
  - A diff >= MW must yield out_mant_small=0; the shifter guarantees this for diff >= 32 via its clear path, and for MW <= diff < 32 by ordinary shifting.
- Sticky: computed in S0 as the OR of mant_small bits below position diff. If diff >= MW, sticky = OR of all mant_small bits. Zero operand gives sticky=0.
- out_special: set in S0 if either exponent is 255.
- Latency:
  - Shifter latency SL = (clog2(MW)+1)/2 if clog2(MW) >= 3, else 1. Default MW=27 gives SL=3.
  - Total accept-to-FIFO-write latency L = 1 + SL (default 4 cycles).
  - A valid bit plus sideband (exp, signs, mant_big, sticky, swapped, special) is delayed exactly SL cycles to align with the shifter output.
- Flow control is credit based:
  - in_ready = (fifo_count + inflight) < FIFO_DEPTH.
  - inflight increments on accept and decrements on pipeline-exit write. A simultaneous inc and dec leaves it unchanged.
  - FIFO write on pipeline exit is unconditional and the FIFO must never overflow; assert this in simulation.
- FIFO:
  - Show-ahead: out_* reflects the head whenever out_valid=1.
  - Simultaneous push and pop keeps the count. A pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order preserved: outputs are in acceptance order.
- Throughput: one pair per cycle sustained when out_ready=1.

Test Plan:
- Basic: A=0x3F800000 (1.0), B=0x3F000000 (0.5) -> out_exp=0x7F, out_mant_big=0x4000000, out_mant_small=0x2000000, out_sticky=0, out_swapped=0. out_valid rises 4 cycles after accept when the FIFO is empty.
- Swap and tie:
  - A=0x3F000000, B=0x40000000 -> out_swapped=1, out_exp=0x80, out_mant_small=0x1000000.
  - A=B=0x3F800000 -> out_swapped=0, out_mant_small=0x4000000.
- Sticky and large diff:
  - A=0x3F800000, B=0x33800001 (diff 24) -> out_mant_small=0x4, out_sticky=1.
  - B=0x2D000000 (diff 37) -> out_mant_small=0, out_sticky=1.
  - B=0x00000000 -> out_mant_small=0, out_sticky=0.
- Special: A=0x7F800000 or B=0x7FC00000 -> out_special=1.
- Backpressure: hold out_ready=0 and offer 12 back-to-back pairs -> exactly 8 accepted, in_ready=0 thereafter, no overflow. Release out_ready -> 8 results in order, then remaining 4 accepted.
- Reset mid-stream: assert rst for 1 cycle with 3 in flight and 2 buffered -> out_valid=0 next cycle, no stale outputs appear afterward, and in_ready returns high.
